// File: rtl/node_inject_port.sv
// Per-node injection stage: buffers core packets, stamps the source ID and
// feeds the crossbar input, dropping packets addressed to nonexistent nodes.

`ifndef NUMNODES
`define NUMNODES 6
`endif

package node_inject_pkg;
  localparam int NUM_NODES = `NUMNODES;
  // Wide enough that NUM_NODES itself is representable as a (bad) dest.
  localparam int NODE_W    = $clog2(NUM_NODES + 1);
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [NODE_W-1:0] dest;
    logic [NODE_W-1:0] src;
    logic [DATA_W-1:0] data;
  } pkt_t;
endpackage

module node_inject_port
  import node_inject_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             core_valid,
  input  pkt_t             core_pkt,
  output logic             core_ready,
  input  logic             xbar_full,
  input  logic             xbar_ack,
  output pkt_t             xbar_pkt,
  output logic             xbar_valid,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             ack_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [NODE_W-1:0] LAST_DEST = NODE_W'(NUM_NODES);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  pkt_t          mem [DEPTH];
  pkt_t          stamped;
  logic          enq, dest_ok, wr_en, issue, issued_q;

  always_comb begin
    stamped     = core_pkt;
    stamped.src = NODE_W'(NODE_ID);
  end

  assign core_ready = (count != (PW+1)'(DEPTH));
  assign enq        = core_valid & core_ready;
  assign dest_ok    = (core_pkt.dest < LAST_DEST);
  assign wr_en      = enq & dest_ok;
  assign issue      = (count != '0) & ~xbar_full;
  assign xbar_valid = issue;
  assign xbar_pkt   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= stamped;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, issue})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Acceptance check: the crossbar must echo every issue exactly one cycle later.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      issued_q <= 1'b0;
      ack_err  <= 1'b0;
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      issued_q <= issue;
      if (xbar_ack != issued_q) ack_err <= 1'b1;
      if (xbar_ack && (sent_cnt != '1)) sent_cnt <= sent_cnt + CNT_W'(1);
      if (enq && !dest_ok && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_node_inject_port.sv
// Scoreboard bench for node_inject_port: a main instance (NODE_ID=3) and a
// narrow-counter instance for drop-counter saturation.

module tb_node_inject_port;
  import node_inject_pkg::*;

  localparam int MY_ID = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l;
  logic        core_valid, core_ready, xbar_full, xbar_ack, xbar_valid, ack_err;
  pkt_t        core_pkt, xbar_pkt;
  logic [15:0] sent_cnt, drop_cnt;

  logic        s_valid, s_ready, s_full, s_ack, s_xvalid, s_err;
  pkt_t        s_pkt, s_xpkt;
  logic [1:0]  s_sent, s_drop;

  node_inject_port #(.NODE_ID(MY_ID), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_l(rst_l), .core_valid(core_valid), .core_pkt(core_pkt),
    .core_ready(core_ready), .xbar_full(xbar_full), .xbar_ack(xbar_ack),
    .xbar_pkt(xbar_pkt), .xbar_valid(xbar_valid), .sent_cnt(sent_cnt),
    .drop_cnt(drop_cnt), .ack_err(ack_err)
  );

  node_inject_port #(.NODE_ID(0), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_l(rst_l), .core_valid(s_valid), .core_pkt(s_pkt),
    .core_ready(s_ready), .xbar_full(s_full), .xbar_ack(s_ack),
    .xbar_pkt(s_xpkt), .xbar_valid(s_xvalid), .sent_cnt(s_sent),
    .drop_cnt(s_drop), .ack_err(s_err)
  );

  int   errors = 0;
  int   checks = 0;
  pkt_t exp_q[$];
  pkt_t mon_e;
  int   exp_sent = 0;
  int   exp_drop = 0;
  bit   ack_auto = 1'b1;
  bit   force_ack = 1'b0;
  bit   pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor/responder: compare each issued packet, echo an ack next cycle.
  initial begin
    xbar_ack = 1'b0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (rst_l && xbar_valid) begin
        if (exp_q.size() == 0) check("spurious_issue", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("pkt", xbar_pkt, mon_e);
        end
        pend = 1'b1;
      end
      @(posedge clk);
      #1;
      xbar_ack = (ack_auto & pend) | force_ack;
      if (xbar_ack && rst_l) exp_sent++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, core_ready, 1);
    check({tag, "_valid"}, xbar_valid, 0);
    check({tag, "_sent"},  sent_cnt, 0);
    check({tag, "_drop"},  drop_cnt, 0);
    check({tag, "_err"},   ack_err, 0);
  endtask

  task automatic reset_dut();
    rst_l = 1'b0;
    core_valid = 1'b0;
    xbar_full = 1'b0;
    force_ack = 1'b0;
    #1;
    check_reset_outputs("rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    exp_sent = 0;
    exp_drop = 0;
    @(negedge clk) rst_l = 1'b1;
    @(posedge clk);
    #3;
  endtask

  // Offer a packet and hold it until handshaken; core_valid left high.
  task automatic send(input logic [NODE_W-1:0] dest, input logic [DATA_W-1:0] data);
    pkt_t p, e;
    int   n = 0;
    bit   ok = 1'b1;
    p.dest = dest;
    p.src  = '1;
    p.data = data;
    core_pkt = p;
    core_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (core_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 0, 1);
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      #3;
    end
    if (ok) begin
      if (dest < NODE_W'(NUM_NODES)) begin
        e = p;
        e.src = NODE_W'(MY_ID);
        exp_q.push_back(e);
      end else exp_drop++;
    end
    @(posedge clk);
    #3;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #3;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    core_pkt = '0;
    s_valid = 1'b0;
    s_full = 1'b1;
    s_ack = 1'b0;
    s_pkt = '0;
    s_pkt.dest = '1;
    reset_dut();

    // Drop-counter saturation on the 2-bit instance.
    s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #3;
      check("sat_drop", s_drop, (i > 3) ? 3 : i);
    end
    s_valid = 1'b0;
    check("sat_no_issue", s_xvalid, 0);

    // Single packet, 1-cycle latency, src stamped.
    send(2, 32'h1111_0001);
    core_valid = 1'b0;
    @(negedge clk);
    check("latency1_valid", xbar_valid, 1);
    drain();
    check("single_sent", sent_cnt, exp_sent);
    check("single_sent_one", sent_cnt, 1);
    check("single_err", ack_err, 0);

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) begin
      send(i % NUM_NODES, 32'h2000_0000 + i);
      check("b2b_ready", core_ready, 1);
    end
    core_valid = 1'b0;
    drain();
    check("b2b_sent", sent_cnt, exp_sent);
    check("b2b_sent_nine", sent_cnt, 9);

    // Backpressure: fill, hold, release.
    xbar_full = 1'b1;
    for (int i = 0; i < 4; i++) send(5 - i, 32'h3000_0000 + i);
    core_pkt.dest = 0;
    core_pkt.data = 32'h3000_0004;
    @(negedge clk);
    check("bp_full_ready", core_ready, 0);
    check("bp_hold_valid", xbar_valid, 0);
    @(posedge clk);
    #3;
    xbar_full = 1'b0;
    @(negedge clk);
    check("bp_release_ready", core_ready, 0);
    check("bp_release_valid", xbar_valid, 1);
    @(posedge clk);
    #3;
    send(0, 32'h3000_0004);
    core_valid = 1'b0;
    drain();
    check("bp_sent", sent_cnt, exp_sent);

    // Bad destination is dropped; following packet unaffected.
    send(NODE_W'(NUM_NODES), 32'h4000_0000);
    send(1, 32'h4000_0001);
    core_valid = 1'b0;
    drain();
    check("bad_drop", drop_cnt, exp_drop);
    check("bad_drop_one", drop_cnt, 1);
    check("bad_err", ack_err, 0);

    // Unsolicited ack.
    @(negedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    #3;
    force_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("spur_ack_err", ack_err, 1);
    repeat (3) @(posedge clk);
    #3;
    check("spur_ack_sticky", ack_err, 1);
    check("spur_ack_sent", sent_cnt, exp_sent);
    reset_dut();

    // Withheld ack.
    ack_auto = 1'b0;
    send(4, 32'h5000_0000);
    core_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("withheld_err", ack_err, 1);
    check("withheld_sent", sent_cnt, 0);
    ack_auto = 1'b1;
    reset_dut();

    // Asynchronous reset mid-burst discards queued packets.
    xbar_full = 1'b1;
    for (int i = 0; i < 3; i++) send(i, 32'h6000_0000 + i);
    core_valid = 1'b0;
    send(NODE_W'(NUM_NODES), 32'h6000_00ff);
    core_valid = 1'b0;
    check("mid_drop_pre", drop_cnt, 1);
    @(posedge clk);
    #3;
    rst_l = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    exp_sent = 0;
    exp_drop = 0;
    xbar_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_valid", xbar_valid, 0);
    end
    check("post_reset_sent", sent_cnt, 0);
    check("post_reset_err", ack_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
